// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end.
//   CPU_DATA_W / CPU_ADDR_W : instruction and PC widths
//   CPU_PC_STEP             : byte increment between sequential instructions
//   ST_*                    : fetch FSM state encoding
package cpu_pkg;
  localparam int CPU_DATA_W  = 16;
  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_PC_STEP = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;
endpackage

// File: rtl/fetch_queue.sv
// Small shift-style FIFO holding fetched {instr, pc} entries.
// Slot 0 is always the head, so the head output is a plain register, and
// every slot at or above the count is kept at zero (empty head reads 0).
//   flush_i : drop all entries (wins over push/pop)
//   push_i  : write din_i behind the last valid entry
//   pop_i   : remove the head (ignored when empty)
//   count_o : number of valid entries
//   head_o  : head entry, zero when empty; valid_o : count_o != 0
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 din_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [W-1:0]                 head_o,
  output logic                         valid_o
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] slot_q, slot_d;
  logic [CW-1:0]           cnt_q, cnt_d, wr_idx;
  logic                    pop_v;

  assign pop_v = pop_i && (cnt_q != '0);

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    // write slot accounts for the same-cycle shift caused by a pop
    wr_idx = cnt_q - CW'(pop_v);
    if (flush_i) begin
      slot_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop_v) begin
        for (int i = 0; i < DEPTH-1; i++) slot_d[i] = slot_q[i+1];
        slot_d[DEPTH-1] = '0;
      end
      if (push_i)
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == wr_idx) slot_d[i] = din_i;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_v);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = slot_q[0];
  assign valid_o = (cnt_q != '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory handshake
// (one outstanding request) and hands {instr, pc} pairs to decode through
// a small prefetch queue.
//   clock, reset_n          : clock, async active-low reset
//   imem_req/addr/ack/rdata : instruction memory handshake (word address)
//   ir_valid/data/pc/ready  : valid/ready output toward decode
//   redirect/redirect_pc    : flush everything and restart at redirect_pc
module instr_fetch_unit import cpu_pkg::*; #(
  parameter int DATA_W                = CPU_DATA_W,
  parameter int ADDR_W                = CPU_ADDR_W,
  parameter int PC_STEP               = CPU_PC_STEP,
  parameter int QDEPTH                = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CW = $clog2(QDEPTH+1);

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-3:0]        addr_q;
  logic [CW-1:0]            count;
  logic [CW:0]              cnt_nxt;
  logic                     push, pop, credit;
  logic [DATA_W+ADDR_W-1:0] head;

  assign pop  = ir_valid && ir_ready;
  assign push = (state_q == ST_WAIT) && imem_ack && !redirect;

  // Occupancy after this edge; a request issued now lands in the slot this
  // leaves free, so credit exists while it stays below QDEPTH.
  assign cnt_nxt = redirect ? '0
                 : ({1'b0, count} + (CW+1)'(push) - (CW+1)'(pop));
  assign credit  = cnt_nxt < (CW+1)'(QDEPTH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!redirect && credit) state_d = ST_WAIT;
      ST_WAIT: begin
        if (redirect)      state_d = imem_ack ? ST_IDLE : ST_DRAIN;
        else if (imem_ack) state_d = credit ? ST_WAIT : ST_IDLE;
      end
      ST_DRAIN: if (imem_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redirect_pc & ~ADDR_W'(3);
    else if (push) pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // address only loads when a request is (re)issued, so it holds the
      // stale target through DRAIN while pc_q already points at the redirect
      if (state_d == ST_WAIT) addr_q <= pc_d[ADDR_W-1:2];
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = addr_q;

  fetch_queue #(.W(DATA_W+ADDR_W), .DEPTH(QDEPTH)) u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .flush_i (redirect),
    .push_i  (push),
    .din_i   ({imem_rdata, pc_q}),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head),
    .valid_o (ir_valid)
  );

  assign ir_data = head[DATA_W+ADDR_W-1:ADDR_W];
  assign ir_pc   = head[ADDR_W-1:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clock, reset_n;
  logic        imem_req, imem_ack;
  logic [13:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        ir_valid, ir_ready, redirect;
  logic [15:0] ir_data, ir_pc, redirect_pc;

  instr_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          lat    = 1;
  int          wcnt   = 0;
  int          nacks  = 0;
  logic [15:0] prog [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory model: ack once the request has been held for lat cycles
  task automatic mem_drive();
    imem_ack   = imem_req && reset_n && (wcnt >= lat - 1);
    imem_rdata = imem_ack ? prog[imem_addr[2:0]] : 16'hDEAD;
  endtask

  task automatic tick();
    logic done, busy;
    done = imem_req && imem_ack;
    busy = imem_req;
    @(posedge clock); #1;
    if (done) begin wcnt = 0; nacks++; end
    else if (busy) wcnt++;
    mem_drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    wcnt = 0; imem_ack = 1'b0; imem_rdata = '0;
    #2;
    reset_n = 1'b1;
    mem_drive();
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20 && !ir_valid; n++) tick();
    chk(tag, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    prog = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
             16'h5555, 16'h6666, 16'h7777, 16'h8888};
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_data",  32'(ir_data),  32'd0);
    chk("rst_pc",    32'(ir_pc),    32'd0);

    // zero-wait streaming, one instruction per cycle
    reset_n = 1'b1;
    mem_drive();
    tick();
    chk("s_req",   32'(imem_req),  32'd1);
    chk("s_addr",  32'(imem_addr), 32'd0);
    chk("s_valid", 32'(ir_valid),  32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s_v",    32'(ir_valid), 32'd1);
      chk("s_pc",   32'(ir_pc),    32'(4 * i));
      chk("s_data", 32'(ir_data),  32'(prog[i]));
    end

    // backpressure: only QDEPTH entries fetched, then order preserved
    ir_ready = 1'b0;
    do_reset();
    nacks = 0;
    repeat (6) tick();
    chk("bp_req",   32'(imem_req), 32'd0);
    chk("bp_nacks", 32'(nacks),    32'd2);
    chk("bp_pc0",   32'(ir_pc),    32'h0);
    chk("bp_d0",    32'(ir_data),  32'(prog[0]));
    ir_ready = 1'b1;
    tick();
    chk("bp_pc4", 32'(ir_pc), 32'h4);
    tick();
    chk("bp_pc8", 32'(ir_pc),   32'h8);
    chk("bp_d8",  32'(ir_data), 32'(prog[2]));

    // 3-cycle memory, redirect in the 2nd wait cycle -> DRAIN
    lat = 3;
    do_reset();
    tick();
    chk("dr_req1", 32'(imem_req), 32'd1);
    chk("dr_ack1", 32'(imem_ack), 32'd0);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0011;
    tick();
    redirect = 1'b0;
    chk("dr_req",   32'(imem_req),  32'd1);
    chk("dr_stale", 32'(imem_addr), 32'd0);
    chk("dr_ack",   32'(imem_ack),  32'd1);
    chk("dr_valid", 32'(ir_valid),  32'd0);
    tick();
    chk("dr_idle", 32'(imem_req), 32'd0);
    chk("dr_v2",   32'(ir_valid), 32'd0);
    tick();
    chk("dr_req2", 32'(imem_req),  32'd1);
    chk("dr_addr", 32'(imem_addr), 32'h4);
    wait_valid("dr_timeout");
    chk("dr_pc",   32'(ir_pc),   32'h10);
    chk("dr_data", 32'(ir_data), 32'(prog[4]));

    // redirect coincident with ack: ack data discarded
    lat = 1;
    mem_drive();
    chk("ra_ack", 32'(imem_ack), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("ra_valid", 32'(ir_valid), 32'd0);
    chk("ra_data",  32'(ir_data),  32'd0);
    chk("ra_pc0",   32'(ir_pc),    32'd0);
    chk("ra_req0",  32'(imem_req), 32'd0);
    tick();
    chk("ra_req",  32'(imem_req),  32'd1);
    chk("ra_addr", 32'(imem_addr), 32'h10);
    tick();
    chk("ra_v",  32'(ir_valid), 32'd1);
    chk("ra_pc", 32'(ir_pc),    32'h40);
    chk("ra_d",  32'(ir_data),  32'(prog[0]));

    // redirect to top of memory (low bits ignored), PC wraps
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    chk("wr_addr", 32'(imem_addr), 32'h3FFF);
    tick();
    chk("wr_pc1", 32'(ir_pc),   32'hFFFC);
    chk("wr_d1",  32'(ir_data), 32'(prog[7]));
    tick();
    chk("wr_pc2", 32'(ir_pc),   32'h0000);
    chk("wr_d2",  32'(ir_data), 32'(prog[0]));

    // async reset mid-WAIT, late ack ignored, restart at RESET_PC
    ir_ready = 1'b0;
    lat = 3;
    mem_drive();
    tick();
    chk("ar_req_pre", 32'(imem_req), 32'd1);
    chk("ar_v_pre",   32'(ir_valid), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_req",   32'(imem_req), 32'd0);
    chk("ar_valid", 32'(ir_valid), 32'd0);
    chk("ar_pc",    32'(ir_pc),    32'd0);
    wcnt = 0;
    #1;
    reset_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'hBAD0;
    tick();
    chk("ar_req2",  32'(imem_req),  32'd1);
    chk("ar_addr",  32'(imem_addr), 32'd0);
    chk("ar_v2",    32'(ir_valid),  32'd0);
    ir_ready = 1'b1;
    wait_valid("ar_timeout");
    chk("ar_pc0", 32'(ir_pc),   32'd0);
    chk("ar_d0",  32'(ir_data), 32'(prog[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
